sha256_nonce_driver: RTL

Nonce-search sequencer for the miner datapath, sitting directly around the single-block SHA-256 core. It accepts a mining job, builds each padded 512-bit message block from a 44-byte prefix plus a 32-bit nonce, and sequences the core through reset/start/done for each nonce. It compares every digest against a 256-bit target and reports the first hit, or reports exhaustion when the nonce range is used up.

---
 rtl/sha256_drv_pkg.sv | 18 +
 rtl/sha256_block_pack.sv | 13 +
 rtl/sha256_nonce_driver.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sha256_drv_pkg.sv
// Shared types and constants for the SHA-256 nonce-search driver.
// Optional core watchdog is enabled with SHA256_DRV_WATCHDOG_EN.
package sha256_drv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        CSTART,
        WAIT,
        CMP
    } drv_state_t;

    localparam logic [31:0] PAD_WORD     = 32'h8000_0000;
    localparam logic [31:0] LEN_WORD     = 32'h0000_0180;
    localparam int          WDOG_LIMIT   = 127;
    localparam int          PREFIX_WORDS = 11;

endpackage

// File: rtl/sha256_block_pack.sv
// Builds the padded 512-bit block: 11 prefix words, nonce, pad, length.
// Word i of the block occupies bits [32i+:32].
module sha256_block_pack
    import sha256_drv_pkg::*;
(
    input  logic [32*PREFIX_WORDS-1:0] prefix_i,
    input  logic [31:0]                nonce_i,
    output logic [511:0]               block_o
);

    assign block_o = {LEN_WORD, 32'h0, 32'h0, PAD_WORD, nonce_i, prefix_i};

endmodule

// File: rtl/sha256_nonce_driver.sv
// Sequences the SHA-256 core over a nonce range and reports the first hit.
// Core watchdog is compiled in with SHA256_DRV_WATCHDOG_EN.
module sha256_nonce_driver
    import sha256_drv_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [32*PREFIX_WORDS-1:0] job_prefix,
    input  logic [255:0]               job_target,
    input  logic [31:0]                job_nonce_start,
    input  logic [31:0]                job_nonce_end,
    input  logic                       abort,
    output logic                       core_reset,
    output logic                       core_start,
    output logic [511:0]               core_block,
    input  logic                       core_done,
    input  logic [255:0]               core_digest,
    output logic                       found_valid,
    output logic [31:0]                found_nonce,
    output logic [255:0]               found_digest,
    output logic                       exhausted,
    output logic                       wdog_err,
    output logic                       busy
);

    drv_state_t                 state_q, state_d;
    logic [32*PREFIX_WORDS-1:0] prefix_q, prefix_d;
    logic [255:0]               target_q, target_d;
    logic [31:0]                end_q, end_d;
    logic [31:0]                nonce_q, nonce_d;
    logic                       crst_q, crst_d;
    logic                       fvalid_q, fvalid_d;
    logic [31:0]                fnonce_q, fnonce_d;
    logic [255:0]               fdigest_q, fdigest_d;
    logic                       exh_q, exh_d;
    logic [511:0]               block;
`ifdef SHA256_DRV_WATCHDOG_EN
    logic [6:0]                 wcnt_q, wcnt_d;
    logic                       wdog_q, wdog_d;
`endif

    sha256_block_pack u_pack (
        .prefix_i (prefix_q),
        .nonce_i  (nonce_q),
        .block_o  (block)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            prefix_q  <= '0;
            target_q  <= '0;
            end_q     <= '0;
            nonce_q   <= '0;
            crst_q    <= 1'b1;
            fvalid_q  <= 1'b0;
            fnonce_q  <= '0;
            fdigest_q <= '0;
            exh_q     <= 1'b0;
`ifdef SHA256_DRV_WATCHDOG_EN
            wcnt_q    <= '0;
            wdog_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prefix_q  <= prefix_d;
            target_q  <= target_d;
            end_q     <= end_d;
            nonce_q   <= nonce_d;
            crst_q    <= crst_d;
            fvalid_q  <= fvalid_d;
            fnonce_q  <= fnonce_d;
            fdigest_q <= fdigest_d;
            exh_q     <= exh_d;
`ifdef SHA256_DRV_WATCHDOG_EN
            wcnt_q    <= wcnt_d;
            wdog_q    <= wdog_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        prefix_d  = prefix_q;
        target_d  = target_q;
        end_d     = end_q;
        nonce_d   = nonce_q;
        crst_d    = 1'b0;
        fvalid_d  = 1'b0;
        fnonce_d  = fnonce_q;
        fdigest_d = fdigest_q;
        exh_d     = 1'b0;
`ifdef SHA256_DRV_WATCHDOG_EN
        wcnt_d    = wcnt_q;
        wdog_d    = 1'b0;
`endif
        // abort outranks every state action, including a hit in CMP
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
            crst_d  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (job_valid) begin
                        prefix_d = job_prefix;
                        target_d = job_target;
                        end_d    = job_nonce_end;
                        nonce_d  = job_nonce_start;
                        crst_d   = 1'b1;
                        state_d  = CRST;
                    end
                end
                CRST: state_d = CSTART;
                CSTART: begin
                    state_d = WAIT;
`ifdef SHA256_DRV_WATCHDOG_EN
                    wcnt_d  = '0;
`endif
                end
                WAIT: begin
                    if (core_done) begin
                        state_d = CMP;
`ifdef SHA256_DRV_WATCHDOG_EN
                    end else if (wcnt_q == 7'(WDOG_LIMIT - 1)) begin
                        wdog_d  = 1'b1;
                        crst_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wcnt_d  = wcnt_q + 7'd1;
`endif
                    end
                end
                CMP: begin
                    if (core_digest < target_q) begin
                        fvalid_d  = 1'b1;
                        fnonce_d  = nonce_q;
                        fdigest_d = core_digest;
                        state_d   = IDLE;
                    end else if (nonce_q == end_q) begin
                        exh_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        nonce_d = nonce_q + 32'd1;
                        crst_d  = 1'b1;
                        state_d = CRST;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign job_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign core_reset   = crst_q;
    assign core_start   = (state_q == CSTART);
    assign core_block   = (state_q == IDLE) ? '0 : block;
    assign found_valid  = fvalid_q;
    assign found_nonce  = fnonce_q;
    assign found_digest = fdigest_q;
    assign exhausted    = exh_q;
`ifdef SHA256_DRV_WATCHDOG_EN
    assign wdog_err     = wdog_q;
`else
    assign wdog_err     = 1'b0;
`endif

endmodule
